// File: rtl/mont_mul_ctrl.sv
// Bit-serial Montgomery multiplier controller: result = a*b*2^-N mod m, driving one shared registered adder.
// Build option MONT_SKIP_ZERO_EN: skip the b-add for zero bits of a (data-dependent latency).
module mont_mul_ctrl #(
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic         add_shift,
  output logic [N+1:0] add_in_a,
  output logic [N+1:0] add_in_b,
  input  logic [N+2:0] add_result,
  input  logic         add_done
);

  localparam int IW = $clog2(N);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ADDB_REQ,
    S_ADDB_WAIT,
    S_ADDM_REQ,
    S_ADDM_WAIT,
    S_SUB_REQ,
    S_SUB_WAIT,
    S_DONE
  } state_t;

  // Adder handshake: add_start pulses for one cycle in a *_REQ state; operands and
  // selects stay stable through the matching *_WAIT state until add_done is seen.
  state_t         state, state_d;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_q;
  logic [N-1:0]   m_q;
  logic [N+1:0]   c_q;
  logic [IW-1:0]  i_q;
  logic           addb_now;
  logic           addb_next;

  // a_sh[0] is the current bit of a; a_sh[1] is the next one.
`ifdef MONT_SKIP_ZERO_EN
  assign addb_now  = a_sh[0];
  assign addb_next = a_sh[1];
`else
  assign addb_now  = 1'b1;
  assign addb_next = 1'b1;
`endif

  always_comb begin
    state_d      = state;
    add_start    = 1'b0;
    add_subtract = 1'b0;
    add_shift    = 1'b0;
    add_in_a     = '0;
    add_in_b     = '0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = addb_now ? S_ADDB_REQ : S_ADDM_REQ;
      end
      S_ADDB_REQ, S_ADDB_WAIT: begin
        add_start = (state == S_ADDB_REQ);
        add_in_a  = c_q;
        add_in_b  = a_sh[0] ? {2'b00, b_q} : '0;
        if (state == S_ADDB_REQ) state_d = S_ADDB_WAIT;
        else if (add_done)       state_d = S_ADDM_REQ;
      end
      S_ADDM_REQ, S_ADDM_WAIT: begin
        add_start = (state == S_ADDM_REQ);
        add_shift = 1'b1;
        add_in_a  = c_q;
        add_in_b  = c_q[0] ? {2'b00, m_q} : '0;
        if (state == S_ADDM_REQ) begin
          state_d = S_ADDM_WAIT;
        end else if (add_done) begin
          if (i_q == IW'(N - 1)) state_d = S_SUB_REQ;
          else                   state_d = addb_next ? S_ADDB_REQ : S_ADDM_REQ;
        end
      end
      S_SUB_REQ, S_SUB_WAIT: begin
        add_start    = (state == S_SUB_REQ);
        add_subtract = 1'b1;
        add_in_a     = c_q;
        add_in_b     = {2'b00, m_q};
        if (state == S_SUB_REQ) state_d = S_SUB_WAIT;
        else if (add_done)      state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      i_q    <= '0;
      result <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= in_a;
            b_q  <= in_b;
            m_q  <= in_m;
          end
        end
        S_LOAD: begin
          c_q <= '0;
          i_q <= '0;
        end
        S_ADDB_WAIT: begin
          if (add_done) c_q <= add_result[N+1:0];
        end
        S_ADDM_WAIT: begin
          if (add_done) begin
            c_q  <= add_result[N+1:0];
            i_q  <= i_q + 1'b1;
            a_sh <= a_sh >> 1;
          end
        end
        S_SUB_WAIT: begin
          // Bit N+2 is the borrow: set means C < m, so C is already reduced.
          if (add_done) result <= add_result[N+2] ? c_q[N-1:0] : add_result[N-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Bench for mont_mul_ctrl: directed vector table, random vectors against a modular-arithmetic
// model, stalled-adder / re-start run and an asynchronous reset in the middle of an operation.
module tb_mont_mul_ctrl;
  localparam int N = 512;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic [N-1:0] result;
  logic         done, busy, add_start, add_subtract, add_shift;
  logic [N+1:0] add_in_a, add_in_b;
  logic [N+2:0] add_result;
  logic         add_done;

  int checks = 0;
  int errors = 0;

  mont_mul_ctrl #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract), .add_shift(add_shift),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- registered adder model ----------------
  int           add_extra = 0;
  logic         outst, pend;
  int           cnt;
  logic [N+2:0] res_pend;
  logic [N+1:0] cap_a, cap_b;
  logic         cap_sub, cap_sh;

  function automatic logic [N+2:0] adder_fn(input logic [N+1:0] x, input logic [N+1:0] y,
                                            input logic sub, input logic sh);
    logic [N+2:0] s;
    if (sub) s = {1'b0, x} - {1'b0, y};
    else begin
      s = {1'b0, x} + {1'b0, y};
      if (sh) s = s >> 1;
    end
    return s;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_done   <= 1'b0;
      add_result <= '0;
      outst      <= 1'b0;
      pend       <= 1'b0;
      cnt        <= 0;
    end else begin
      add_done <= 1'b0;
      if (add_done) outst <= 1'b0;
      if (add_start) begin
        cap_a   <= add_in_a;
        cap_b   <= add_in_b;
        cap_sub <= add_subtract;
        cap_sh  <= add_shift;
        outst   <= 1'b1;
        if (add_extra == 0) begin
          add_result <= adder_fn(add_in_a, add_in_b, add_subtract, add_shift);
          add_done   <= 1'b1;
        end else begin
          res_pend <= adder_fn(add_in_a, add_in_b, add_subtract, add_shift);
          pend     <= 1'b1;
          cnt      <= add_extra;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          add_result <= res_pend;
          add_done   <= 1'b1;
          pend       <= 1'b0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  // ---------------- reference model and helpers ----------------
  // a*b mod m, then N modular halvings (divide by 2 mod an odd m).
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    logic [2*N+1:0] t, mm;
    mm = {{(N+2){1'b0}}, m};
    t  = ({{(N+2){1'b0}}, a} * {{(N+2){1'b0}}, b}) % mm;
    for (int k = 0; k < N; k++) t = t[0] ? (t + mm) >> 1 : t >> 1;
    return t[N-1:0];
  endfunction

  function automatic int exp_lat(input logic [N-1:0] a);
`ifdef MONT_SKIP_ZERO_EN
    return 2 * N + 2 * $countones(a) + 4;
`else
    return 4 * N + 4;
`endif
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] r;
    for (int k = 0; k < N / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [N+2:0] act, input logic [N+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " result"}, {3'b0, result}, '0);
    check_int({name, " done"}, int'(done), 0);
    check_int({name, " busy"}, int'(busy), 0);
    check_int({name, " add_start"}, int'(add_start), 0);
    check_int({name, " add_subtract"}, int'(add_subtract), 0);
    check_int({name, " add_shift"}, int'(add_shift), 0);
    check({name, " add_in_a"}, {1'b0, add_in_a}, '0);
    check({name, " add_in_b"}, {1'b0, add_in_b}, '0);
  endtask

  // One full operation; lat=0 skips the latency check, no_b checks b is never offered.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] m, input logic [N-1:0] exp_r, input int lat,
                        input bit no_b, input bit reenter, input int extra);
    int k, busy_low, hold_err, shift_reqs, bad_shift, saw_b;
    bit got;
    k = 0; got = 0; busy_low = 0; hold_err = 0; shift_reqs = 0; bad_shift = 0; saw_b = 0;
    add_extra = extra;
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    while (!got && k < 12 * N + 100) begin
      @(negedge clk);
      k++;
      start = reenter && (k == 3 || k == 400);
      if (reenter && k == 3) begin
        in_a = ~a; in_b = b ^ 1; in_m = m ^ 2;
      end
      if (!busy) busy_low++;
      if (add_start && add_shift) begin
        shift_reqs++;
        if (add_subtract) bad_shift++;
      end
      if (add_in_b == {2'b00, b}) saw_b++;
      if (outst && {add_in_a, add_in_b, add_subtract, add_shift} !== {cap_a, cap_b, cap_sub, cap_sh})
        hold_err++;
      if (done) got = 1;
    end
    start = 1'b0;
    check_int({name, " completed"}, int'(got), 1);
    check({name, " result"}, {3'b0, result}, {3'b0, exp_r});
    if (lat > 0) check_int({name, " latency"}, k, lat);
    check_int({name, " busy gaps"}, busy_low, 0);
    check_int({name, " operand hold"}, hold_err, 0);
    check_int({name, " shift requests"}, shift_reqs, N);
    check_int({name, " shift with subtract"}, bad_shift, 0);
    if (no_b) check_int({name, " addb offered b"}, saw_b, 0);
    @(negedge clk);
    check_int({name, " done single pulse"}, int'(done), 0);
    check_int({name, " busy after done"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    check({name, " result held"}, {3'b0, result}, {3'b0, exp_r});
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] a, b, m, exp_r;
    bit           no_b;
  } vec_t;

  // ---------------- main sequence ----------------
  initial begin
    vec_t         vecs[3];
    logic [N-1:0] a, b, m;
    int           done_seen;

    vecs[0] = '{"a3b5m7", N'(3), N'(5), N'(7), N'(2), 1'b0};
    vecs[1] = '{"a0b5m7", N'(0), N'(5), N'(7), N'(0), 1'b1};
    vecs[2] = '{"a1b1m7", N'(1), N'(1), N'(7), N'(2), 1'b0};

    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle");

    for (int v = 0; v < 3; v++)
      run_op(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].exp_r,
             exp_lat(vecs[v].a), vecs[v].no_b, 1'b0, 0);

    for (int v = 0; v < 20; v++) begin
      m = rand_word();
      m[N-1] = 1'b1;
      m[0] = 1'b1;
      b = rand_word() % m;
      a = rand_word();
      run_op($sformatf("rand%0d", v), a, b, m, mont_ref(a, b, m), exp_lat(a), 1'b0, 1'b0, 0);
    end

    // Adder stalled by 3 extra cycles per request, with start pulsed while busy.
    m = rand_word(); m[N-1] = 1'b1; m[0] = 1'b1;
    b = rand_word() % m;
    a = rand_word();
    run_op("stall_restart", a, b, m, mont_ref(a, b, m), 0, 1'b0, 1'b1, 3);

    // Asynchronous reset in the middle of an operation.
    add_extra = 0;
    m = rand_word(); m[N-1] = 1'b1; m[0] = 1'b1;
    b = rand_word() % m;
    a = rand_word();
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 4 * 200; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_int("midrun busy", int'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    check_outputs_zero("midrun reset");
    @(negedge clk);
    check_int("midrun done seen", done_seen + int'(done), 0);
    resetn = 1'b1;
    run_op("after_reset", a, b, m, mont_ref(a, b, m), exp_lat(a), 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
